bcd_serial_tx: RTL and testbench

- Upstream feeder for the serial BCD odd-parity generator.
- Accepts parallel BCD digits over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each digit out one bit per clock on `x`, with 4 bits per digit and no gaps between consecutive digits.
- Rejects non-BCD codes (10..15) with a one-cycle error pulse, so the parity stage only ever receives well-formed 4-bit frames.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_fifo.sv | 57 +++++
 rtl/bcd_serial_tx.sv | 103 ++++++++++
 tb/tb_bcd_serial_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, shifter state encoding and BCD validity check for the
// serial BCD transmit/receive path.
package bcd_pkg;
  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         FRAME_BITS = 4;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_fifo.sv
// Small power-of-two FIFO for BCD digits; head is readable combinationally.
// Push when full and pop when empty are ignored.
module bcd_fifo
  import bcd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = BCD_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/bcd_serial_tx.sv
// BCD digit serializer: valid/ready digit input, FIFO, 4-bit gapless frames on x.
// Latency: digit written at edge k (empty FIFO, IDLE) is loaded at k+1; bit 1 is on x from k+1 to k+2.
module bcd_serial_tx
  import bcd_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BCD_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic             bcd_err,
  output logic             busy
);
  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [1:0] LAST_BIT = 2'(FRAME_BITS - 1);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] sr_q, sr_d, head;
  logic [1:0]       bitcnt_q, bitcnt_d, bit_idx;
  logic             err_q, err_d;
  logic             fire, push, pop, full, empty, shifting;
  logic [CW-1:0]    count;

  bcd_fifo #(.DEPTH(DEPTH), .W(BCD_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (din),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Invalid codes still complete the handshake; they are just never stored.
  assign din_ready = ~full;
  assign fire      = din_valid & din_ready;
  assign push      = fire & is_bcd(din);
  assign err_d     = fire & ~is_bcd(din);

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          sr_d     = head;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_d = '0;
          if (!empty) begin
            pop  = 1'b1;
            sr_d = head;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode flops only; for 2-bit counts 3-n equals ~n.
  assign shifting    = (state_q == S_SHIFT);
  assign bit_idx     = MSB_FIRST ? ~bitcnt_q : bitcnt_q;
  assign x           = shifting & sr_q[bit_idx];
  assign x_valid     = shifting;
  assign frame_first = shifting & (bitcnt_q == 2'd0);
  assign frame_last  = shifting & (bitcnt_q == LAST_BIT);
  assign bcd_err     = err_q;
  assign busy        = (count != '0) | shifting;
endmodule

// File: tb/tb_bcd_serial_tx.sv
// Scoreboard bench: MSB-first (a) and LSB-first (b) instances share stimulus;
// accepted digits queue expected frame bits, monitors pop on every x_valid.
module tb_bcd_serial_tx;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] din = 4'd0;
  logic       din_valid = 1'b0;

  logic a_rdy, a_x, a_xv, a_ff, a_fl, a_err, a_busy;
  logic b_rdy, b_x, b_xv, b_ff, b_fl, b_err, b_busy;

  int n_vec = 0, n_mis = 0;
  logic [2:0] qa[$], qb[$];
  logic [2:0] ea, eb;
  int err_a = 0, err_b = 0, run_a = 0, last_run_a = 0, stall_cnt = 0;

  always #5 clock = ~clock;

  bcd_serial_tx #(.DEPTH(2), .MSB_FIRST(1'b1)) dut_a (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(a_rdy), .x(a_x), .x_valid(a_xv), .frame_first(a_ff),
    .frame_last(a_fl), .bcd_err(a_err), .busy(a_busy));

  bcd_serial_tx #(.DEPTH(2), .MSB_FIRST(1'b0)) dut_b (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(b_rdy), .x(b_x), .x_valid(b_xv), .frame_first(b_ff),
    .frame_last(b_fl), .bcd_err(b_err), .busy(b_busy));

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ent(input logic [3:0] d, input int i, input bit msb);
    logic b;
    b = msb ? d[3-i] : d[i];
    return {b, i == 0, i == 3};
  endfunction

  // Monitors
  always @(negedge clock) begin
    if (reset) begin
      if (a_xv) begin
        if (qa.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL a_unexpected: x_valid=1 with no digit queued");
        end else begin
          ea = qa.pop_front();
          chk("a_frame_bit", {a_x, a_ff, a_fl}, ea);
        end
      end
      if (b_xv) begin
        if (qb.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL b_unexpected: x_valid=1 with no digit queued");
        end else begin
          eb = qb.pop_front();
          chk("b_frame_bit", {b_x, b_ff, b_fl}, eb);
        end
      end
      if (a_err) err_a++;
      if (b_err) err_b++;
      if (a_xv) run_a++;
      else begin
        if (run_a > 0) last_run_a = run_a;
        run_a = 0;
      end
    end
  end

  task automatic send(input logic [3:0] d);
    int t;
    t = 0;
    @(negedge clock);
    din = d;
    din_valid = 1'b1;
    while (!a_rdy && t < 50) begin
      stall_cnt++;
      @(negedge clock);
      t++;
    end
    if (t >= 50) chk("send_timeout_ready", a_rdy, 1);
    chk("ready_match", b_rdy, a_rdy);
    @(posedge clock);
    if (d <= 4'd9) begin
      for (int i = 0; i < 4; i++) begin
        qa.push_back(ent(d, i, 1'b1));
        qb.push_back(ent(d, i, 1'b0));
      end
    end
    #1 din_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy) && t < 200) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    chk({tag, "_qa_empty"}, qa.size(), 0);
    chk({tag, "_qb_empty"}, qb.size(), 0);
    chk({tag, "_a_busy"}, a_busy, 0);
    chk({tag, "_b_busy"}, b_busy, 0);
    chk({tag, "_a_xvalid"}, a_xv, 0);
  endtask

  // Directed single-digit check with hand-computed time-ordered bits.
  task automatic single(input string tag, input logic [3:0] d,
                        input logic [3:0] seq_a, input logic [3:0] seq_b);
    send(d);
    @(negedge clock);
    chk({tag, "_lat_xvalid"}, a_xv, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk({tag, "_a_xv"}, a_xv, 1);
      chk({tag, "_a_x"}, a_x, seq_a[3-i]);
      chk({tag, "_b_x"}, b_x, seq_b[3-i]);
      chk({tag, "_a_first"}, a_ff, (i == 0) ? 1 : 0);
      chk({tag, "_a_last"}, a_fl, (i == 3) ? 1 : 0);
    end
    drain(tag);
  endtask

  initial begin
    int t, ea0, eb0;
    // Reset held with valid asserted
    din = 4'd3;
    din_valid = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("rst_a_ready", a_rdy, 1);
      chk("rst_b_ready", b_rdy, 1);
      chk("rst_a_xvalid", a_xv, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_b_busy", b_busy, 0);
    end
    din_valid = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("idle_a_xvalid", a_xv, 0);
      chk("idle_a_x", a_x, 0);
      chk("idle_a_busy", a_busy, 0);
      chk("idle_a_err", a_err, 0);
    end

    // Single digit 5: MSB 0,1,0,1 ; LSB 1,0,1,0
    single("d5", 4'd5, 4'b0101, 4'b1010);
    // Digit 8: MSB 1,0,0,0 ; LSB 0,0,0,1
    single("d8", 4'd8, 4'b1000, 4'b0001);

    // Stream 0..9 with back-to-back offers
    stall_cnt = 0;
    for (int d = 0; d < 10; d++) send(4'(d));
    drain("stream");
    chk("stream_gapless_run", last_run_a, 40);
    chk("stream_ready_dropped", (stall_cnt > 0) ? 1 : 0, 1);

    // Invalid codes
    ea0 = err_a;
    eb0 = err_b;
    send(4'd10);
    @(negedge clock);
    chk("err10_pulse", a_err, 1);
    send(4'd15);
    @(negedge clock);
    chk("err15_pulse", b_err, 1);
    @(negedge clock);
    chk("err_pulse_end", a_err, 0);
    send(4'd3);
    drain("inv");
    chk("err_count_a", err_a - ea0, 2);
    chk("err_count_b", err_b - eb0, 2);

    // Reset mid-frame of digit 7 with digit 2 queued
    send(4'd7);
    send(4'd2);
    t = 0;
    while (!(a_xv && a_ff) && t < 20) begin @(negedge clock); t++; end
    chk("mid_first_seen", a_ff, 1);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("mid_rst_a_xvalid", a_xv, 0);
    chk("mid_rst_b_xvalid", b_xv, 0);
    chk("mid_rst_a_busy", a_busy, 0);
    chk("mid_rst_a_ready", a_rdy, 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk("post_rst_a_xvalid", a_xv, 0);
      chk("post_rst_b_busy", b_busy, 0);
    end
    send(4'd6);
    drain("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
